nibble_cascade_cmp: RTL and testbench

NIBBLE_CASCADE_CMP -- requirements
Module: nibble_cascade_cmp

---
 rtl/nibble_cascade_cmp.sv | 138 +++++++++++++
 tb/tb_nibble_cascade_cmp.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_cascade_cmp.sv
// Multi-cycle magnitude comparator: walks the operands one nibble per cycle, LSB first.
// Define SIGNED_CMP_EN to compare as two's complement instead of unsigned.
module nibble_cascade_cmp #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic                 E,
    output logic                 L,
    output logic                 G
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, stateNext;
    logic [W-1:0]    opA, opB, opANext, opBNext;
    logic [IDXW-1:0] idx, idxNext;
    logic            cascE, cascL, cascG;
    logic            cascENext, cascLNext, cascGNext;
    logic            eNext, lNext, gNext;
    logic            busyNext, doneNext;
    logic [3:0]      nibA, nibB;
    logic            stepE, stepL, stepG;

    assign nibA = opA[{idx, 2'b00} +: 4];
    assign nibB = opB[{idx, 2'b00} +: 4];

    // One cascade step; a higher nibble that differs overrides lower decisions.
    always_comb begin
        stepE = cascE & (nibA == nibB);
        stepL = cascL;
        stepG = cascG;
        if (nibA < nibB) begin
            stepL = 1'b1;
            stepG = 1'b0;
        end else if (nibA > nibB) begin
            stepG = 1'b1;
            stepL = 1'b0;
        end
    end

    always_comb begin
        stateNext = state;
        opANext   = opA;
        opBNext   = opB;
        idxNext   = idx;
        cascENext = cascE;
        cascLNext = cascL;
        cascGNext = cascG;
        eNext     = E;
        lNext     = L;
        gNext     = G;
        case (state)
            IDLE: begin
                if (start) begin
                    opANext   = a;
                    opBNext   = b;
                    idxNext   = '0;
                    cascENext = 1'b1;
                    cascLNext = 1'b0;
                    cascGNext = 1'b0;
                    stateNext = RUN;
                end
            end
            RUN: begin
                cascENext = stepE;
                cascLNext = stepL;
                cascGNext = stepG;
                if (idx == LAST_IDX) begin
                    eNext = stepE;
`ifdef SIGNED_CMP_EN
                    // Differing sign bits invert the unsigned ordering.
                    lNext = (opA[W-1] ^ opB[W-1]) ? stepG : stepL;
                    gNext = (opA[W-1] ^ opB[W-1]) ? stepL : stepG;
`else
                    lNext = stepL;
                    gNext = stepG;
`endif
                    stateNext = DONE;
                end else begin
                    idxNext = idx + IDXW'(1);
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        busyNext = (stateNext != IDLE);
        doneNext = (stateNext == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opA   <= '0;
            opB   <= '0;
            idx   <= '0;
            cascE <= 1'b0;
            cascL <= 1'b0;
            cascG <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            E     <= 1'b0;
            L     <= 1'b0;
            G     <= 1'b0;
        end else begin
            state <= stateNext;
            opA   <= opANext;
            opB   <= opBNext;
            idx   <= idxNext;
            cascE <= cascENext;
            cascL <= cascLNext;
            cascG <= cascGNext;
            busy  <= busyNext;
            done  <= doneNext;
            E     <= eNext;
            L     <= lNext;
            G     <= gNext;
        end
    end

endmodule

// File: tb/tb_nibble_cascade_cmp.sv
// Self-checking bench for nibble_cascade_cmp against an integer-compare reference model.
// Build with +define+SIGNED_CMP_EN to check the two's complement variant.
module tb_nibble_cascade_cmp;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] aIn = '0;
    logic [W-1:0] bIn = '0;
    logic         busy, done, E, L, G;

    int nTests = 0;
    int nFail  = 0;

    nibble_cascade_cmp #(.NIBBLES(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (aIn),
        .b    (bIn),
        .busy (busy),
        .done (done),
        .E    (E),
        .L    (L),
        .G    (G)
    );

    always #5 clk = ~clk;

    // Reference: plain integer comparison, returns {E,L,G}.
    function automatic logic [2:0] refCmp(input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy;
`ifdef SIGNED_CMP_EN
        sx = longint'($signed(x));
        sy = longint'($signed(y));
`else
        sx = longint'(x);
        sy = longint'(y);
`endif
        if (sx < sy) return 3'b010;
        if (sx > sy) return 3'b001;
        return 3'b100;
    endfunction

    // Presents operands with start for one edge; returns just after the sampling edge.
    task automatic startCompare(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        aIn   = x;
        bIn   = y;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Edges counted include the start-sampling edge; stops at the negedge where done is seen.
    task automatic waitDone(output int edges, output int busyCyc, output bit timedOut);
        edges    = 1;
        busyCyc  = 0;
        timedOut = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) busyCyc++;
            if (done) begin
                timedOut = 1'b0;
                break;
            end
            @(posedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nTests++;
        if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b want 0", busy); end
        nTests++;
        if (done !== 1'b0) begin nFail++; $display("FAIL reset_done: got %b want 0", done); end
        nTests++;
        if ({E, L, G} !== 3'b000) begin nFail++; $display("FAIL reset_elg: got %b want 000", {E, L, G}); end
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] xs [4] = '{16'h1234, 16'hA5A5, 16'hF000, 16'h8000};
        logic [W-1:0] ys [4] = '{16'h1235, 16'hA5A5, 16'h0FFF, 16'h0001};
        int edges, busyCyc;
        bit to;
        for (int i = 0; i < 4; i++) begin
            startCompare(xs[i], ys[i]);
            waitDone(edges, busyCyc, to);
            nTests++;
            if (to) begin
                nFail++; $display("FAIL directed%0d_timeout: done never seen", i);
            end else begin
                nTests++;
                if ({E, L, G} !== refCmp(xs[i], ys[i])) begin
                    nFail++; $display("FAIL directed%0d_elg: got %b want %b", i, {E, L, G}, refCmp(xs[i], ys[i]));
                end
                nTests++;
                if (edges != N + 1) begin
                    nFail++; $display("FAIL directed%0d_latency: got %0d want %0d", i, edges, N + 1);
                end
                nTests++;
                if (busyCyc != N + 1) begin
                    nFail++; $display("FAIL directed%0d_busy: got %0d want %0d", i, busyCyc, N + 1);
                end
            end
        end
    endtask

    // Result holds and done stays low while inputs wiggle without start.
    task automatic test_hold();
        logic [2:0] exp;
        int edges, busyCyc;
        bit to;
        startCompare(16'h4321, 16'h4320);
        waitDone(edges, busyCyc, to);
        exp = refCmp(16'h4321, 16'h4320);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 aIn = W'($urandom);
            bIn = W'($urandom);
            @(negedge clk);
            nTests++;
            if ({done, busy, E, L, G} !== {2'b00, exp}) begin
                nFail++; $display("FAIL hold%0d: got done/busy/elg %b want %b", k, {done, busy, E, L, G}, {2'b00, exp});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x1, y1, x2, y2;
        int edges, busyCyc;
        bit to;
        x1 = 16'h0F00; y1 = 16'h0E99;
        x2 = 16'h0001; y2 = 16'h7FFF;
        startCompare(x1, y1);
        @(negedge clk);
        aIn = y2; bIn = x2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        aIn = W'($urandom); bIn = W'($urandom);
        waitDone(edges, busyCyc, to);
        nTests++;
        if (to || {E, L, G} !== refCmp(x1, y1)) begin
            nFail++; $display("FAIL ignore_start: got %b timeout %0d want %b", {E, L, G}, to, refCmp(x1, y1));
        end
        // Start held through DONE and the following IDLE edge; only the IDLE edge may accept it.
        aIn = x2; bIn = y2; start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(edges, busyCyc, to);
        nTests++;
        if (to || edges != N + 1) begin
            nFail++; $display("FAIL b2b_latency: got %0d timeout %0d want %0d", edges, to, N + 1);
        end
        nTests++;
        if ({E, L, G} !== refCmp(x2, y2)) begin
            nFail++; $display("FAIL b2b_elg: got %b want %b", {E, L, G}, refCmp(x2, y2));
        end
    endtask

    task automatic test_reset_mid();
        int edges, busyCyc, doneSeen;
        bit to;
        startCompare(16'h1111, 16'h2222);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        nTests++;
        if ({busy, done, E, L, G} !== 5'b00000) begin
            nFail++; $display("FAIL midreset_state: got busy/done/elg %b want 00000", {busy, done, E, L, G});
        end
        doneSeen = 0;
        for (int k = 0; k < N + 4; k++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        nTests++;
        if (doneSeen != 0 || {E, L, G} !== 3'b000) begin
            nFail++; $display("FAIL midreset_nodone: got %0d pulses elg %b want 0 pulses elg 000", doneSeen, {E, L, G});
        end
        startCompare(16'h2222, 16'h1111);
        waitDone(edges, busyCyc, to);
        nTests++;
        if (to || edges != N + 1 || {E, L, G} !== refCmp(16'h2222, 16'h1111)) begin
            nFail++; $display("FAIL midreset_fresh: got elg %b edges %0d want %b edges %0d",
                              {E, L, G}, edges, refCmp(16'h2222, 16'h1111), N + 1);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        int edges, busyCyc;
        bit to;
        for (int i = 0; i < 300; i++) begin
            x = W'($urandom);
            case ($urandom_range(0, 3))
                0: y = W'($urandom);
                1: y = x;
                2: y = x ^ (W'($urandom_range(1, 15)) << (4 * $urandom_range(0, N - 1)));
                default: y = x ^ {1'b1, (W - 1)'($urandom_range(0, 3))};
            endcase
            startCompare(x, y);
            waitDone(edges, busyCyc, to);
            nTests++;
            if (to || edges != N + 1 || {E, L, G} !== refCmp(x, y)) begin
                nFail++; $display("FAIL random%0d a=%h b=%h: got elg %b edges %0d want %b edges %0d",
                                  i, x, y, {E, L, G}, edges, refCmp(x, y), N + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
